// File: rtl/gemm_cmd_decoder.sv
// ---------------------------------------------------------------------------
// gemm_cmd_decoder
//
// Parses the 32-bit command word stream coming out of the command FIFO and
// hands one decoded command (op, id, len, up to three payload words) to the
// master controller dispatch logic per valid/ready transfer. Malformed
// headers are reported on the error port, their payload words are drained
// from the FIFO, and they are never issued.
//
// Optional feature macro: GEMM_CMD_DEC_ID_CHECK_EN
//   When defined, the id of every issued command is compared against the id
//   of the previously issued command + 1 (mod 256). A mismatch raises error
//   code 3 in the cycle o_cmd_valid rises; the command is still issued.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_word_data    command word from the FIFO
//   i_word_valid   FIFO word valid
//   o_word_ready   word accepted when valid & ready
//   o_cmd_valid    decoded command valid
//   i_cmd_ready    consumer accepts the command
//   o_cmd_op       header[7:0]
//   o_cmd_id       header[15:8]
//   o_cmd_len      header[23:16], payload length in bytes
//   o_cmd_payload  word1 in [31:0], word2 in [63:32], word3 in [95:64]
//   o_err_valid    1-cycle pulse: malformed command dropped / id error
//   o_err_code     1 unknown op, 2 len mismatch, 3 id sequence
//   o_err_cnt      saturating count of o_err_valid pulses
//   o_busy         parser is inside a command (not waiting for a header)
// ---------------------------------------------------------------------------
module gemm_cmd_decoder #(
    parameter int WORD_W    = 32,
    parameter int MAX_PLD_W = 3,
    parameter int ERR_CNT_W = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [WORD_W-1:0]             i_word_data,
    input  logic                          i_word_valid,
    output logic                          o_word_ready,
    output logic                          o_cmd_valid,
    input  logic                          i_cmd_ready,
    output logic [7:0]                    o_cmd_op,
    output logic [7:0]                    o_cmd_id,
    output logic [7:0]                    o_cmd_len,
    output logic [MAX_PLD_W*WORD_W-1:0]   o_cmd_payload,
    output logic                          o_err_valid,
    output logic [1:0]                    o_err_code,
    output logic [ERR_CNT_W-1:0]          o_err_cnt,
    output logic                          o_busy
);

    // A bad header may announce up to ceil(255/4) = 64 words to drain.
    localparam int CNT_W = 7;
    localparam int IDX_W = (MAX_PLD_W > 1) ? $clog2(MAX_PLD_W) : 1;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_PLD   = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   word_cnt;
    logic [IDX_W-1:0]   pld_idx;
    logic               accept;
    logic [7:0]         hdr_op;
    logic [7:0]         hdr_id;
    logic [7:0]         hdr_len;
    logic [CNT_W-1:0]   hdr_words;

`ifdef GEMM_CMD_DEC_ID_CHECK_EN
    logic [7:0]         exp_id;
    logic               id_seen;
`endif

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_len(input logic [7:0] op);
        case (op)
            8'hF0, 8'hF1, 8'hF2: return 8'd12;
            8'hF3, 8'hF4:        return 8'd4;
            default:             return 8'd0;
        endcase
    endfunction

    // ceil(len / 4) payload words
    function automatic logic [CNT_W-1:0] len_words(input logic [7:0] len);
        logic [8:0] t;
        t = {1'b0, len} + 9'd3;
        return t[8:2];
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign accept    = i_word_valid & o_word_ready;
    assign hdr_op    = i_word_data[7:0];
    assign hdr_id    = i_word_data[15:8];
    assign hdr_len   = i_word_data[23:16];
    assign hdr_words = len_words(hdr_len);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_HDR;
            word_cnt      <= '0;
            pld_idx       <= '0;
            o_word_ready  <= 1'b0;
            o_cmd_valid   <= 1'b0;
            o_cmd_op      <= '0;
            o_cmd_id      <= '0;
            o_cmd_len     <= '0;
            o_cmd_payload <= '0;
            o_err_valid   <= 1'b0;
            o_err_code    <= '0;
            o_err_cnt     <= '0;
            o_busy        <= 1'b0;
`ifdef GEMM_CMD_DEC_ID_CHECK_EN
            exp_id        <= '0;
            id_seen       <= 1'b0;
`endif
        end else begin
            o_err_valid <= 1'b0;
            case (state)
                S_HDR: begin
                    // Ready rises here the first cycle after reset as well.
                    o_word_ready <= 1'b1;
                    if (accept) begin
                        o_cmd_op      <= hdr_op;
                        o_cmd_id      <= hdr_id;
                        o_cmd_len     <= hdr_len;
                        o_cmd_payload <= '0;
                        pld_idx       <= '0;
                        word_cnt      <= hdr_words;
                        if (op_known(hdr_op) && hdr_len == exp_len(hdr_op)) begin
                            state  <= S_PLD;
                            o_busy <= 1'b1;
                        end else begin
                            o_err_valid <= 1'b1;
                            o_err_code  <= op_known(hdr_op) ? 2'd2 : 2'd1;
                            o_err_cnt   <= sat_inc(o_err_cnt);
                            // A zero-length bad header has nothing to drain.
                            if (hdr_words != '0) begin
                                state  <= S_DRAIN;
                                o_busy <= 1'b1;
                            end
                        end
                    end
                end

                S_PLD: begin
                    if (accept) begin
                        for (int k = 0; k < MAX_PLD_W; k++) begin
                            if (int'(pld_idx) == k) begin
                                o_cmd_payload[k*WORD_W +: WORD_W] <= i_word_data;
                            end
                        end
                        pld_idx  <= pld_idx + 1'b1;
                        word_cnt <= word_cnt - 1'b1;
                        if (word_cnt == CNT_W'(1)) begin
                            state        <= S_ISSUE;
                            o_cmd_valid  <= 1'b1;
                            o_word_ready <= 1'b0;
`ifdef GEMM_CMD_DEC_ID_CHECK_EN
                            if (id_seen && o_cmd_id != exp_id) begin
                                o_err_valid <= 1'b1;
                                o_err_code  <= 2'd3;
                                o_err_cnt   <= sat_inc(o_err_cnt);
                            end
                            exp_id  <= o_cmd_id + 8'd1;
                            id_seen <= 1'b1;
`endif
                        end
                    end
                end

                S_ISSUE: begin
                    // Outputs stay frozen until the consumer takes the command.
                    if (i_cmd_ready) begin
                        o_cmd_valid  <= 1'b0;
                        o_word_ready <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= S_HDR;
                    end
                end

                S_DRAIN: begin
                    if (accept) begin
                        word_cnt <= word_cnt - 1'b1;
                        if (word_cnt == CNT_W'(1)) begin
                            state  <= S_HDR;
                            o_busy <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_gemm_cmd_decoder
//
// Directed bench for gemm_cmd_decoder. Each command is described as a header
// plus its payload words; a command-level model turns that description into
// the expected issued command and/or error report, and a negedge compare
// process checks the DUT against those expectations every cycle. Literal
// checks pin the model on the hand-worked vectors.
// ---------------------------------------------------------------------------
module tb_gemm_cmd_decoder;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic [31:0]  i_word_data;
    logic         i_word_valid;
    logic         o_word_ready;
    logic         o_cmd_valid;
    logic         i_cmd_ready;
    logic [7:0]   o_cmd_op;
    logic [7:0]   o_cmd_id;
    logic [7:0]   o_cmd_len;
    logic [95:0]  o_cmd_payload;
    logic         o_err_valid;
    logic [1:0]   o_err_code;
    logic [15:0]  o_err_cnt;
    logic         o_busy;

    always #5 i_clk = ~i_clk;

    gemm_cmd_decoder dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_word_data   (i_word_data),
        .i_word_valid  (i_word_valid),
        .o_word_ready  (o_word_ready),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_cmd_op      (o_cmd_op),
        .o_cmd_id      (o_cmd_id),
        .o_cmd_len     (o_cmd_len),
        .o_cmd_payload (o_cmd_payload),
        .o_err_valid   (o_err_valid),
        .o_err_code    (o_err_code),
        .o_err_cnt     (o_err_cnt),
        .o_busy        (o_busy)
    );

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [95:0] pld;
    } cmd_t;

    typedef struct {
        logic [1:0]  code;
        logic [15:0] cnt;
    } err_t;

    cmd_t        exp_cmd_q[$];
    err_t        exp_err_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_err_cnt = 0;
    logic [7:0]  m_exp_id = '0;
    bit          m_id_seen = 1'b0;
    bit          chk_en = 1'b0;
    logic [15:0] id_base;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_len_bytes(input logic [7:0] op);
        case (op)
            8'hF0, 8'hF1, 8'hF2: return 12;
            8'hF3, 8'hF4:        return 4;
            default:             return -1;
        endcase
    endfunction

    task automatic push_err(input logic [1:0] code);
        err_t e;
        if (m_err_cnt < 65535) m_err_cnt++;
        e.code = code;
        e.cnt  = 16'(m_err_cnt);
        exp_err_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        bit r;
        bit ok;
        ok = 1'b0;
        i_word_data  = w;
        i_word_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            r = o_word_ready;
            @(posedge i_clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        i_word_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL word_accept_timeout: word %h not accepted in 200 cycles", w);
        end
    endtask

    // Sends a header and nsend payload words, recording what the decoder
    // must report for that command.
    task automatic send_cmd(input logic [31:0] hdr, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2, input int nsend);
        logic [31:0] w[3];
        int          el;
        int          nwords;
        bit          good;
        cmd_t        c;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        el     = exp_len_bytes(hdr[7:0]);
        nwords = (int'(hdr[23:16]) + 3) / 4;
        good   = (el >= 0) && (int'(hdr[23:16]) == el);
        send_word(hdr);
        if (el < 0)     push_err(2'd1);
        else if (!good) push_err(2'd2);
        for (int i = 0; i < nsend; i++) send_word(w[i]);
        if (good && nsend == nwords) begin
            c.op  = hdr[7:0];
            c.id  = hdr[15:8];
            c.len = hdr[23:16];
            c.pld = '0;
            for (int i = 0; i < nwords; i++) c.pld[i*32 +: 32] = w[i];
`ifdef GEMM_CMD_DEC_ID_CHECK_EN
            if (m_id_seen && c.id != m_exp_id) push_err(2'd3);
            m_exp_id  = c.id + 8'd1;
            m_id_seen = 1'b1;
`endif
            exp_cmd_q.push_back(c);
        end
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        i_reset_n = 1'b0;
        #2;
        check("rst_cmd_valid",  128'(o_cmd_valid),  128'h0);
        check("rst_word_ready", 128'(o_word_ready), 128'h0);
        check("rst_busy",       128'(o_busy),       128'h0);
        check("rst_err_valid",  128'(o_err_valid),  128'h0);
        check("rst_err_code",   128'(o_err_code),   128'h0);
        check("rst_err_cnt",    128'(o_err_cnt),    128'h0);
        check("rst_op_id_len",  128'({o_cmd_op, o_cmd_id, o_cmd_len}), 128'h0);
        check("rst_payload",    128'(o_cmd_payload), 128'h0);
        exp_cmd_q.delete();
        exp_err_q.delete();
        m_err_cnt = 0;
        m_id_seen = 1'b0;
        m_exp_id  = '0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison against the model's expectations.
    bit           hold_prev = 1'b0;
    logic [119:0] snap;
    logic [1:0]   last_code = 2'd0;

    always @(negedge i_clk) begin
        cmd_t c;
        err_t e;
        if (!chk_en) begin
            hold_prev = 1'b0;
            last_code = 2'd0;
        end else begin
            if (o_cmd_valid) begin
                if (!hold_prev) begin
                    if (exp_cmd_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_cmd: got op %h id %h, none expected", o_cmd_op, o_cmd_id);
                    end else begin
                        c = exp_cmd_q.pop_front();
                        check("cmd_op",      128'(o_cmd_op),      128'(c.op));
                        check("cmd_id",      128'(o_cmd_id),      128'(c.id));
                        check("cmd_len",     128'(o_cmd_len),     128'(c.len));
                        check("cmd_payload", 128'(o_cmd_payload), 128'(c.pld));
                    end
                end else begin
                    check("cmd_stable", 128'({o_cmd_op, o_cmd_id, o_cmd_len, o_cmd_payload}), 128'(snap));
                end
                snap = {o_cmd_op, o_cmd_id, o_cmd_len, o_cmd_payload};
                check("busy_while_valid", 128'(o_busy), 128'h1);
            end
            check("word_ready_vs_valid", 128'(o_word_ready), 128'(!o_cmd_valid));
            hold_prev = o_cmd_valid && !i_cmd_ready;

            if (o_err_valid) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_err: got code %0d, none expected", o_err_code);
                end else begin
                    e = exp_err_q.pop_front();
                    check("err_code", 128'(o_err_code), 128'(e.code));
                    check("err_cnt",  128'(o_err_cnt),  128'(e.cnt));
                    last_code = e.code;
                end
            end else begin
                check("err_code_hold", 128'(o_err_code), 128'(last_code));
            end
        end
    end

    initial begin
        i_reset_n    = 1'b0;
        i_word_data  = '0;
        i_word_valid = 1'b0;
        i_cmd_ready  = 1'b1;
        @(posedge i_clk);
        #1;
        do_reset();

        // Fetch: valid one cycle after the last payload word is taken.
        send_cmd(32'h000C01F0, 32'h1000, 32'h0040, 32'h1, 3);
        check("fetch_latency_valid", 128'(o_cmd_valid), 128'h1);
        check("fetch_op",      128'(o_cmd_op),  128'hF0);
        check("fetch_id",      128'(o_cmd_id),  128'h01);
        check("fetch_len",     128'(o_cmd_len), 128'h0C);
        check("fetch_payload", 128'(o_cmd_payload), 128'h00000001_00000040_00001000);
        @(posedge i_clk);
        #1;
        check("fetch_handoff", 128'(o_cmd_valid), 128'h0);

        // wait_tile with the consumer stalling for 5 cycles.
        i_cmd_ready = 1'b0;
        send_cmd(32'h000402F4, 32'h7, 32'h0, 32'h0, 1);
        check("wt_valid",   128'(o_cmd_valid),   128'h1);
        check("wt_payload", 128'(o_cmd_payload), 128'h7);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check("wt_hold_valid",      128'(o_cmd_valid),  128'h1);
            check("wt_hold_word_ready", 128'(o_word_ready), 128'h0);
        end
        i_cmd_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("wt_released_valid", 128'(o_cmd_valid),  128'h0);
        check("wt_released_ready", 128'(o_word_ready), 128'h1);
        check("wt_released_busy",  128'(o_busy),       128'h0);

        // Unknown op with two words to drain, then a normal wait_disp.
        send_cmd(32'h000802AA, 32'h11, 32'h22, 32'h0, 2);
        check("unk_code", 128'(o_err_code), 128'h1);
        check("unk_cnt",  128'(o_err_cnt),  128'h1);
        check("unk_busy_after_drain", 128'(o_busy), 128'h0);
        send_cmd(32'h000403F3, 32'hBEEF, 32'h0, 32'h0, 1);
        check("f3_valid", 128'(o_cmd_valid), 128'h1);
        check("f3_op",    128'(o_cmd_op),    128'hF3);

        // Tile with len 8: dropped with code 2 after draining 2 words.
        send_cmd(32'h000803F2, 32'h5, 32'h6, 32'h0, 2);
        check("len8_code",  128'(o_err_code),  128'h2);
        check("len8_cnt",   128'(o_err_cnt),   128'h2);
        check("len8_valid", 128'(o_cmd_valid), 128'h0);

        // disp with len 0: error, no drain.
        send_cmd(32'h000001F1, 32'h0, 32'h0, 32'h0, 0);
        check("len0_err_pulse", 128'(o_err_valid), 128'h1);
        check("len0_code",      128'(o_err_code),  128'h2);
        check("len0_cnt",       128'(o_err_cnt),   128'h3);
        check("len0_no_drain",  128'(o_busy),      128'h0);
        @(posedge i_clk);
        #1;
        check("len0_pulse_end", 128'(o_err_valid), 128'h0);

        // Reset after two of three tile payload words.
        send_word(32'h000C07F2);
        send_word(32'h0000000A);
        send_word(32'h0000000B);
        check("partial_busy", 128'(o_busy), 128'h1);
        do_reset();

        // Id sequence 5, 6, 9, 10 after reset.
        id_base = o_err_cnt;
        send_cmd(32'h000C05F2, 32'h1, 32'h2, 32'h3, 3);
        send_cmd(32'h000C06F2, 32'h4, 32'h5, 32'h6, 3);
        send_cmd(32'h000C09F2, 32'h7, 32'h8, 32'h9, 3);
        send_cmd(32'h000C0AF2, 32'hA, 32'hB, 32'hC, 3);
        check("id10_payload", 128'(o_cmd_payload), 128'h0000000C_0000000B_0000000A);
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
`ifdef GEMM_CMD_DEC_ID_CHECK_EN
        check("id_seq_err_cnt", 128'(o_err_cnt - id_base), 128'h1);
        check("id_seq_code",    128'(o_err_code),          128'h3);
`else
        check("id_seq_err_cnt", 128'(o_err_cnt - id_base), 128'h0);
`endif

        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        check("cmd_queue_drained", 128'(exp_cmd_q.size()), 128'h0);
        check("err_queue_drained", 128'(exp_err_q.size()), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
